// File: rtl/oai221_bist_pkg.sv
// Shared constants, FSM encoding and golden model for the OAI221 self-test sequencer.
package oai221_bist_pkg;

  localparam int unsigned VEC_W   = 5;
  localparam int unsigned VEC_CNT = 32;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned PASS_W  = 3;
  localparam int unsigned MISR_W  = 16;

  localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Vector bit order: A1=v[0], A2=v[1], B1=v[2], B2=v[3], C=v[4].
  function automatic logic oai221_ref(input logic [VEC_W-1:0] v);
    return ~((v[0] | v[1]) & (v[2] | v[3]) & v[4]);
  endfunction

endpackage

// File: rtl/oai221_bist_misr.sv
// 16-bit ZN signature register with seed load and capture enable.
module oai221_bist_misr
  import oai221_bist_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              seed_ld_i,
  input  logic              en_i,
  input  logic              zn_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (seed_ld_i) begin
      sig_d = MISR_SEED;
    end else if (en_i) begin
      sig_d = ({sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0))
              ^ {{(MISR_W-1){1'b0}}, zn_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/oai221_bist.sv
// Exhaustive OAI221 self-test: drives 32 vectors per pass and checks ZN one cycle later.
// Define OAI221_BIST_MISR_EN to build the ZN signature register; otherwise SIG reads zero.
module oai221_bist
  import oai221_bist_pkg::*;
#(
  parameter int unsigned PASSES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  inout  wire               VDD,
  inout  wire               VSS,
  input  logic              START,
  output logic              A1,
  output logic              A2,
  output logic              B1,
  output logic              B2,
  output logic              C,
  input  logic              ZN,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ERR_W-1:0]  ERR_CNT,
  output logic              FAIL_VLD,
  output logic [VEC_W-1:0]  FAIL_VEC,
  output logic [MISR_W-1:0] SIG
);

  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  logic [1:0]        state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [VEC_W-1:0]  drv_q, drv_d;
  logic              exp_q, exp_d;
  logic [VEC_W-1:0]  idx_q, idx_d;
  logic              chk_q, chk_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_vld_q, fail_vld_d;
  logic [VEC_W-1:0]  fail_vec_q, fail_vec_d;
  logic              start_run;
  logic              mismatch;

  assign start_run = START & ((state_q == StIdle) | (state_q == StDone));
  // chk_q marks a cycle whose ZN belongs to the vector loaded on the previous edge.
  assign mismatch  = chk_q & (ZN != exp_q);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_d     = pass_q;
    drv_d      = '0;
    exp_d      = exp_q;
    idx_d      = idx_q;
    chk_d      = (state_q == StRun);
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;

    if (mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
      if (!fail_vld_q) begin
        fail_vld_d = 1'b1;
        fail_vec_d = idx_q;
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start_run) begin
          state_d    = StRun;
          vec_d      = '0;
          pass_d     = '0;
          err_d      = '0;
          fail_vld_d = 1'b0;
          fail_vec_d = '0;
        end
      end
      StRun: begin
        drv_d = vec_q;
        exp_d = oai221_ref(vec_q);
        idx_d = vec_q;
        vec_d = vec_q + 1'b1;
        if (vec_q == '1) begin
          pass_d = pass_q + 1'b1;
          if (pass_q == PASS_W'(PASSES - 1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      pass_q     <= '0;
      drv_q      <= '0;
      exp_q      <= 1'b0;
      idx_q      <= '0;
      chk_q      <= 1'b0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_q     <= pass_d;
      drv_q      <= drv_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign {C, B2, B1, A2, A1} = drv_q;
  assign BUSY     = (state_q == StRun) | (state_q == StDrain);
  assign DONE     = (state_q == StDone);
  assign PASS     = DONE & (err_q == '0);
  assign ERR_CNT  = err_q;
  assign FAIL_VLD = fail_vld_q;
  assign FAIL_VEC = fail_vec_q;

`ifdef OAI221_BIST_MISR_EN
  oai221_bist_misr u_misr (
    .clk_i     (CLK),
    .rst_i     (RST),
    .seed_ld_i (start_run),
    .en_i      (chk_q),
    .zn_i      (ZN),
    .sig_o     (SIG)
  );
`else
  assign SIG = '0;
`endif

endmodule

// File: tb/tb_oai221_bist.sv
// Bench for oai221_bist: PASSES=1 and PASSES=8 instances, each driving a modelled OAI221 cell.
module tb_oai221_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start8;
  wire         vdd = 1'b1;
  wire         vss = 1'b0;
  int          mode;
  logic [31:0] mask;

  logic [4:0]  drv1, drv8;
  logic        zn1, zn8;
  logic        busy1, busy8, done1, done8, pass1, pass8, fvld1, fvld8;
  logic [7:0]  err1, err8;
  logic [4:0]  fvec1, fvec8;
  logic [15:0] sig1, sig8;

  // Cell under test: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 good with ZN flipped where mask bit set.
  function automatic logic cell_zn(input logic [4:0] v, input int m, input logic [31:0] mk);
    logic good;
    good = !(((v[0] || v[1]) && (v[2] || v[3])) && v[4]);
    case (m)
      0:       return good;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return good ^ mk[v];
    endcase
  endfunction

  assign zn1 = cell_zn(drv1, mode, mask);
  assign zn8 = cell_zn(drv8, mode, mask);

  oai221_bist #(.PASSES(1)) dut1 (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .START(start1),
    .A1(drv1[0]), .A2(drv1[1]), .B1(drv1[2]), .B2(drv1[3]), .C(drv1[4]),
    .ZN(zn1), .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
    .FAIL_VLD(fvld1), .FAIL_VEC(fvec1), .SIG(sig1)
  );

  oai221_bist #(.PASSES(8)) dut8 (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .START(start8),
    .A1(drv8[0]), .A2(drv8[1]), .B1(drv8[2]), .B2(drv8[3]), .C(drv8[4]),
    .ZN(zn8), .BUSY(busy8), .DONE(done8), .PASS(pass8), .ERR_CNT(err8),
    .FAIL_VLD(fvld8), .FAIL_VEC(fvec8), .SIG(sig8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected results from the rules: count mismatches over every pass, keep the first, fold ZN.
  task automatic model(input int passes, input int m, input logic [31:0] mk,
                       output int err, output logic vld, output logic [4:0] vec,
                       output logic pass, output logic [15:0] sig);
    logic [4:0] v;
    logic       z, good;
    err = 0; vld = 1'b0; vec = 5'd0; sig = 16'hFFFF;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < 32; i++) begin
        v    = 5'(i);
        good = cell_zn(v, 0, 32'h0);
        z    = cell_zn(v, m, mk);
        if (z != good) begin
          if (err < 255) err++;
          if (!vld) begin vld = 1'b1; vec = v; end
        end
        sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, z};
      end
    end
    pass = (err == 0);
`ifndef OAI221_BIST_MISR_EN
    sig = 16'h0000;
`endif
  endtask

  task automatic run(input string name, input int sel, input int m, input logic [31:0] mk,
                     input int e_err, input logic e_vld, input logic [4:0] e_vec,
                     input logic e_pass, input logic [15:0] e_sig, input bit midstart);
    int         passes, j, drv_bad;
    logic [4:0] dv, exp_dv;
    logic       bz;
    passes = (sel != 0) ? 8 : 1;
    mode = m; mask = mk;
    @(negedge clk);
    if (sel != 0) start8 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    j = 0; drv_bad = 0;
    bz = (sel != 0) ? busy8 : busy1;
    while (bz && j < 400) begin
      dv     = (sel != 0) ? drv8 : drv1;
      exp_dv = (j == 0) ? 5'd0 : 5'((j - 1) % 32);
      if (dv != exp_dv) drv_bad++;
      if (sel != 0) start8 = midstart && (j == 100);
      @(negedge clk);
      j++;
      bz = (sel != 0) ? busy8 : busy1;
    end
    start8 = 1'b0;
    chk({name, "_busy_cycles"}, 32'(j), 32'(passes * 32 + 1));
    chk({name, "_drive_seq_bad"}, 32'(drv_bad), 32'd0);
    if (sel != 0) begin
      chk({name, "_done"}, {31'b0, done8}, 32'd1);
      chk({name, "_drive_idle"}, {27'b0, drv8}, 32'd0);
      chk({name, "_err_cnt"}, {24'b0, err8}, 32'(e_err));
      chk({name, "_fail_vld"}, {31'b0, fvld8}, {31'b0, e_vld});
      chk({name, "_fail_vec"}, {27'b0, fvec8}, {27'b0, e_vec});
      chk({name, "_pass"}, {31'b0, pass8}, {31'b0, e_pass});
      chk({name, "_sig"}, {16'b0, sig8}, {16'b0, e_sig});
    end else begin
      chk({name, "_done"}, {31'b0, done1}, 32'd1);
      chk({name, "_drive_idle"}, {27'b0, drv1}, 32'd0);
      chk({name, "_err_cnt"}, {24'b0, err1}, 32'(e_err));
      chk({name, "_fail_vld"}, {31'b0, fvld1}, {31'b0, e_vld});
      chk({name, "_fail_vec"}, {27'b0, fvec1}, {27'b0, e_vec});
      chk({name, "_pass"}, {31'b0, pass1}, {31'b0, e_pass});
      chk({name, "_sig"}, {16'b0, sig1}, {16'b0, e_sig});
    end
  endtask

  typedef struct {
    string       name;
    int          sel;
    int          mode;
    logic [31:0] mask;
    int          err;
    logic        vld;
    logic [4:0]  vec;
    logic        pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          m_err;
    logic        m_vld, m_pass;
    logic [4:0]  m_vec;
    logic [15:0] m_sig;
    logic [31:0] rmask;
    int          rsel;

    tbl[0] = '{"good_p1",   0, 0, 32'h0,        0,   1'b0, 5'h00, 1'b1};
    tbl[1] = '{"sa1_p1",    0, 1, 32'h0,        9,   1'b1, 5'h15, 1'b0};
    tbl[2] = '{"sa0_p1",    0, 2, 32'h0,        23,  1'b1, 5'h00, 1'b0};
    tbl[3] = '{"sa1_p8",    1, 1, 32'h0,        72,  1'b1, 5'h15, 1'b0};
    tbl[4] = '{"good_p8",   1, 0, 32'h0,        0,   1'b0, 5'h00, 1'b1};
    tbl[5] = '{"sat_p8",    1, 3, 32'hFFFFFFFF, 255, 1'b1, 5'h00, 1'b0};

    rst = 1'b1; start1 = 1'b0; start8 = 1'b0; mode = 0; mask = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_outs1", {31'b0, |{drv1, busy1, done1, pass1, err1, fvld1, fvec1, sig1}}, 32'd0);
    chk("reset_outs8", {31'b0, |{drv8, busy8, done8, pass8, err8, fvld8, fvec8, sig8}}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      model((tbl[i].sel != 0) ? 8 : 1, tbl[i].mode, tbl[i].mask, m_err, m_vld, m_vec,
            m_pass, m_sig);
      run(tbl[i].name, tbl[i].sel, tbl[i].mode, tbl[i].mask, tbl[i].err, tbl[i].vld,
          tbl[i].vec, tbl[i].pass, m_sig, tbl[i].sel != 0);
    end

    // Abort mid-run with a stuck cell so errors are already accumulating.
    mode = 1;
    @(negedge clk); start1 = 1'b1; start8 = 1'b1;
    @(negedge clk); start1 = 1'b0; start8 = 1'b0;
    repeat (28) @(negedge clk);
    chk("pre_abort_busy", {31'b0, busy1}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs1", {31'b0, |{drv1, busy1, done1, pass1, err1, fvld1, fvec1, sig1}}, 32'd0);
    chk("abort_outs8", {31'b0, |{drv8, busy8, done8, pass8, err8, fvld8, fvec8, sig8}}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model(1, 0, 32'h0, m_err, m_vld, m_vec, m_pass, m_sig);
    run("post_abort_good", 0, 0, 32'h0, m_err, m_vld, m_vec, m_pass, m_sig, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rmask = $urandom();
      if (r == 0) rmask = 32'h0;
      rsel  = int'($urandom_range(0, 1));
      model((rsel != 0) ? 8 : 1, 3, rmask, m_err, m_vld, m_vec, m_pass, m_sig);
      run($sformatf("rand%0d", r), rsel, 3, rmask, m_err, m_vld, m_vec, m_pass, m_sig, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
